// File: rtl/ex_mem_req_pkg.sv
// Shared types and encodings for the EX-stage memory request block:
// load/store one-hot bit positions, access size codes, FSM states and the EX bus layout.
package ex_mem_req_pkg;

  localparam int VADDR_W = 32;
  localparam int DATA_W  = 32;
  localparam int LD_OP_W = 5;
  localparam int ST_OP_W = 3;

  localparam int LD_W  = 0;
  localparam int LD_B  = 1;
  localparam int LD_BU = 2;
  localparam int LD_H  = 3;
  localparam int LD_HU = 4;

  localparam int ST_W = 0;
  localparam int ST_H = 1;
  localparam int ST_B = 2;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DONE  = 2'd2,
    S_DRAIN = 2'd3
  } mem_state_e;

  typedef struct packed {
    logic [VADDR_W-1:0] vaddr;
    logic [LD_OP_W-1:0] ld_op;
    logic [ST_OP_W-1:0] st_op;
    logic [DATA_W-1:0]  st_data;
    logic               ex_in;
  } es_bus_t;

endpackage

// File: rtl/ex_mem_req_store_align.sv
// Combinational address-alignment check plus size/byte-strobe/data replication
// for the data SRAM request of the instruction currently in EX.
module ex_store_align
  import ex_mem_req_pkg::*;
(
  input  logic [VADDR_W-1:0] vaddr,
  input  logic [LD_OP_W-1:0] ld_op,
  input  logic [ST_OP_W-1:0] st_op,
  input  logic [DATA_W-1:0]  st_data,
  output logic               ale,
  output logic [1:0]         size,
  output logic [3:0]         wstrb,
  output logic [DATA_W-1:0]  wdata
);

  always_comb begin
    ale = ((ld_op[LD_W] | st_op[ST_W]) & (vaddr[1:0] != 2'b00)) |
          ((ld_op[LD_H] | ld_op[LD_HU] | st_op[ST_H]) & vaddr[0]);

    size = SIZE_B;
    if (ld_op[LD_W] | st_op[ST_W])
      size = SIZE_W;
    else if (ld_op[LD_H] | ld_op[LD_HU] | st_op[ST_H])
      size = SIZE_H;

    // Loads leave wstrb at zero; wdata is don't-care for them.
    wstrb = 4'b0000;
    wdata = st_data;
    if (st_op[ST_B]) begin
      wstrb = 4'b0001 << vaddr[1:0];
      wdata = {4{st_data[7:0]}};
    end else if (st_op[ST_H]) begin
      wstrb = vaddr[1] ? 4'b1100 : 4'b0011;
      wdata = {2{st_data[15:0]}};
    end else if (st_op[ST_W]) begin
      wstrb = 4'b1111;
    end
  end

endmodule

// File: rtl/ex_mem_req.sv
// EX-stage data SRAM request issue: holds a request until addr_ok, survives flushes
// by draining, and counts abandoned loads whose data_ok responses MS must ignore.
module ex_mem_req
  import ex_mem_req_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               flush,
  input  logic               ds_to_es_valid,
  output logic               es_allow_in,
  input  logic [VADDR_W-1:0] ds_vaddr,
  input  logic [LD_OP_W-1:0] ds_ld_op,
  input  logic [ST_OP_W-1:0] ds_st_op,
  input  logic [DATA_W-1:0]  ds_st_data,
  input  logic               ds_ex_in,
  input  logic               ms_allow_in,
  output logic               es_to_ms_valid,
  input  logic               ms_ex,
  input  logic               ws_ex,
  output logic               data_sram_req,
  output logic               data_sram_wr,
  output logic [1:0]         data_sram_size,
  output logic [VADDR_W-1:0] data_sram_addr,
  output logic [3:0]         data_sram_wstrb,
  output logic [DATA_W-1:0]  data_sram_wdata,
  input  logic               data_sram_addr_ok,
  input  logic               data_sram_data_ok,
  output logic               es_ale,
  output logic [1:0]         es_unaligned_addr,
  output logic               es_mem_issued,
  output logic               ms_drop_data_ok
);

  es_bus_t            es_bus;
  logic               es_valid;
  mem_state_e         state;
  logic [1:0]         drop_cnt;

  logic [VADDR_W-1:0] hold_addr;
  logic [1:0]         hold_size;
  logic [3:0]         hold_wstrb;
  logic [DATA_W-1:0]  hold_wdata;
  logic               hold_wr;
  logic               hold_load;

  logic [1:0]         al_size;
  logic [3:0]         al_wstrb;
  logic [DATA_W-1:0]  al_wdata;
  logic               mem;
  logic               es_ex;
  logic               issue_ok;
  logic               idle_accept;
  logic               es_ready_go;
  logic               handshake;
  logic               use_hold;
  logic               drop_inc;
  logic               drop_dec;

  ex_store_align u_align (
    .vaddr   (es_bus.vaddr),
    .ld_op   (es_bus.ld_op),
    .st_op   (es_bus.st_op),
    .st_data (es_bus.st_data),
    .ale     (es_ale),
    .size    (al_size),
    .wstrb   (al_wstrb),
    .wdata   (al_wdata)
  );

  assign es_unaligned_addr = es_bus.vaddr[1:0];
  assign mem         = (|es_bus.ld_op) | (|es_bus.st_op);
  assign es_ex       = es_bus.ex_in | es_ale;
  assign issue_ok    = es_valid & mem & ~es_ex & ~ms_ex & ~ws_ex & ~flush;
  assign idle_accept = (state == S_IDLE) & issue_ok & data_sram_addr_ok;

  assign es_ready_go    = ~mem | es_ex | (state == S_DONE) | idle_accept;
  assign es_allow_in    = ~es_valid | (es_ready_go & ms_allow_in);
  assign es_to_ms_valid = es_valid & es_ready_go & ~flush;
  assign handshake      = es_to_ms_valid & ms_allow_in;
  assign es_mem_issued  = es_valid & ((state == S_DONE) | idle_accept);

  // Once a request is outstanding the bus may be flushed or refilled, so drive from the snapshot.
  assign use_hold        = (state == S_REQ) | (state == S_DRAIN);
  assign data_sram_req   = (state == S_IDLE) ? issue_ok : (state != S_DONE);
  assign data_sram_addr  = use_hold ? hold_addr  : es_bus.vaddr;
  assign data_sram_size  = use_hold ? hold_size  : al_size;
  assign data_sram_wstrb = use_hold ? hold_wstrb : al_wstrb;
  assign data_sram_wdata = use_hold ? hold_wdata : al_wdata;
  assign data_sram_wr    = use_hold ? hold_wr    : (|es_bus.st_op);

  assign drop_inc = hold_load & (((state == S_REQ)   & flush & data_sram_addr_ok) |
                                 ((state == S_DRAIN) & data_sram_addr_ok) |
                                 ((state == S_DONE)  & flush));
  assign drop_dec = data_sram_data_ok & (drop_cnt != 2'd0);
  assign ms_drop_data_ok = (drop_cnt != 2'd0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      es_valid   <= 1'b0;
      es_bus     <= '0;
      state      <= S_IDLE;
      drop_cnt   <= 2'd0;
      hold_addr  <= '0;
      hold_size  <= 2'd0;
      hold_wstrb <= 4'd0;
      hold_wdata <= '0;
      hold_wr    <= 1'b0;
      hold_load  <= 1'b0;
    end else begin
      if (flush) begin
        es_valid <= 1'b0;
        es_bus   <= '0;
      end else if (es_allow_in) begin
        es_valid <= ds_to_es_valid;
        if (ds_to_es_valid)
          es_bus <= '{vaddr: ds_vaddr, ld_op: ds_ld_op, st_op: ds_st_op,
                      st_data: ds_st_data, ex_in: ds_ex_in};
      end

      case (state)
        S_IDLE: begin
          if (issue_ok && data_sram_addr_ok)
            state <= handshake ? S_IDLE : S_DONE;
          else if (issue_ok)
            state <= S_REQ;
        end
        S_REQ: begin
          if (data_sram_addr_ok)
            state <= flush ? S_IDLE : S_DONE;
          else if (flush)
            state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (data_sram_addr_ok)
            state <= S_IDLE;
        end
        S_DONE: begin
          if (flush || handshake)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (state == S_IDLE && issue_ok) begin
        hold_addr  <= es_bus.vaddr;
        hold_size  <= al_size;
        hold_wstrb <= al_wstrb;
        hold_wdata <= al_wdata;
        hold_wr    <= |es_bus.st_op;
        hold_load  <= |es_bus.ld_op;
      end

      if (drop_inc && !drop_dec && drop_cnt != 2'd3)
        drop_cnt <= drop_cnt + 2'd1;
      else if (drop_dec && !drop_inc)
        drop_cnt <= drop_cnt - 2'd1;
    end
  end

endmodule

// File: doc/ex_mem_req.md
EX_MEM_REQ -- requirements
Module: ex_mem_req

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 resetn  in  1  one clock; reset is synchronous and active-low.
REQ-003 flush  in  1  ertn_flush | wb_ex | tlb_reflush, combined upstream.
REQ-004 ds_to_es_valid  in  1; es_allow_in  out  1  ID->EX handshake.
REQ-005 ds_vaddr  in  32; ds_ld_op  in  5 (one-hot w,b,bu,h,hu); ds_st_op  in  3 (one-hot w,h,b); ds_st_data  in  32; ds_ex_in  in  1 (older-stage exception bits OR'd).
REQ-006 ms_allow_in  in  1; es_to_ms_valid  out  1  EX->MS handshake.
REQ-007 ms_ex  in  1; ws_ex  in  1  exception/ertn present in MS/WB.
REQ-008 data_sram_req  out  1; data_sram_wr  out  1; data_sram_size  out  2; data_sram_addr  out  32; data_sram_wstrb  out  4; data_sram_wdata  out  32; data_sram_addr_ok  in  1; data_sram_data_ok  in  1.
REQ-009 es_ale  out  1; es_unaligned_addr  out  2; es_mem_issued  out  1  (to es_to_ms_bus).
REQ-010 ms_drop_data_ok  out  1  MS shall ignore data_sram_data_ok while high.

Function
REQ-011 Input fields SHALL be registered into es_bus_reg when ds_to_es_valid && es_allow_in; es_valid <= ds_to_es_valid when es_allow_in.
REQ-012 flush SHALL clear es_valid and es_bus_reg at the next edge; es_to_ms_valid SHALL be 0 during flush.
REQ-013 es_ale = (ld_w|st_w)&addr[1:0]!=0 | (ld_h|ld_hu|st_h)&addr[0]; es_ex = ex_in | es_ale.
REQ-014 mem = |ld_op | |st_op; issue_ok = es_valid & mem & ~es_ex & ~ms_ex & ~ws_ex & ~flush.
REQ-015 FSM states IDLE, REQ, DONE, DRAIN.
REQ-016 IDLE: req = issue_ok; req&addr_ok -> DONE; req&~addr_ok -> REQ.
REQ-017 REQ: req=1, addr/size/wstrb/wdata held stable; addr_ok -> DONE; flush&~addr_ok -> DRAIN; flush&addr_ok -> IDLE with drop count +1 if load.
REQ-018 DRAIN: req=1 until addr_ok, then IDLE with drop count +1 if load; no new issue while in DRAIN.
REQ-019 DONE: req=0; es_to_ms handshake -> IDLE; flush -> IDLE with drop count +1 if load.
REQ-020 es_ready_go = ~mem | es_ex | state==DONE | (state==IDLE & req & addr_ok); es_allow_in = ~es_valid | es_ready_go & ms_allow_in; es_to_ms_valid = es_valid & es_ready_go & ~flush.
REQ-021 A request SHALL never be withdrawn before addr_ok; at most one request per instruction.
REQ-022 size: w=2, h=1, b=0; loads use same encoding; wr = |st_op.
REQ-023 wstrb: st_b 4'b0001<<addr[1:0]; st_h addr[1]?4'b1100:4'b0011; st_w 4'b1111; loads 4'b0000.
REQ-024 wdata: st_b {4{data[7:0]}}; st_h {2{data[15:0]}}; st_w data.
REQ-025 Drop counter 2 bits, saturating at 3; decrements on data_ok when nonzero; simultaneous inc/dec leaves it unchanged; ms_drop_data_ok = (cnt!=0).
REQ-026 es_mem_issued = 1 when the instruction leaves EX with a request accepted.

Reset
REQ-027 resetn=0 at an edge: es_valid=0, es_bus_reg=0, state=IDLE, drop counter=0; hence req=0, es_to_ms_valid=0, ms_drop_data_ok=0, es_allow_in=1.
REQ-028 Reset mid-request SHALL abandon the request; memory side is reset by the same resetn.

Structure
REQ-029 State encoding, size codes, ld/st one-hot bit positions and bus widths SHALL live in the shared width.vh header.
REQ-030 One combinational sub-module ex_store_align SHALL compute es_ale, size, wstrb, wdata.

Verification
REQ-031 st_b to 0x1003 data 0x000000AB, addr_ok same cycle -> req 1 cycle, wstrb 4'b1000, wdata 0xABABABAB, size 0, state DONE.
REQ-032 ld_w to 0x2000, addr_ok delayed 3 cycles -> req held 4 cycles with stable addr; es_to_ms_valid rises the cycle after addr_ok.
REQ-033 ld_h to 0x2001 -> es_ale=1, req never asserted, es_to_ms_valid=1 immediately.
REQ-034 ld_w in REQ, flush, addr_ok 2 cycles later -> DRAIN, req held, drop count 1, next data_ok dropped, count returns 0.
REQ-035 st_w with ms_ex=1 -> no request until ms_ex falls; with flush -> instruction discarded, no request.
REQ-036 resetn low while in REQ -> next cycle req=0, state IDLE, es_valid=0, counter 0.
